// File: rtl/adder_4bit_rca_if.sv
// rtl/adder_4bit_rca_if.sv - operand/result bundle for the registered ripple-carry adder
// Defining ADDER_OVERFLOW_EN adds the registered signed-overflow flag.
interface adder_4bit_rca_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output a, b, cin, in_valid,
`ifdef ADDER_OVERFLOW_EN
    input  overflow,
`endif
    input  sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
`ifdef ADDER_OVERFLOW_EN
    output overflow,
`endif
    output sum, cout, out_valid
  );
endinterface

// File: rtl/adder_4bit_rca.sv
// rtl/adder_4bit_rca.sv - registered 4-bit ripple-carry adder built from full-adder cells
// Defining ADDER_OVERFLOW_EN adds a registered two's-complement overflow output.
module adder_4bit_rca_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ c;
  assign co = (a & b) | (c & p);
endmodule

module adder_4bit_rca #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  adder_4bit_rca_if.slave     bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // Carry enters at bit 0 and ripples upward; c[WIDTH] is the carry out.
  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    adder_4bit_rca_fa u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .c  (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

`ifdef ADDER_OVERFLOW_EN
  logic overflow_d, overflow_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.in_valid) begin
      overflow_d = c[WIDTH-1] ^ c[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_adder_4bit_rca.sv
// tb/tb_adder_4bit_rca.sv - table and scoreboard checks for adder_4bit_rca
// Checks overflow too when ADDER_OVERFLOW_EN is defined.
module tb_adder_4bit_rca;
  logic clk;
  logic rst;

  adder_4bit_rca_if #(.WIDTH(4)) bus ();

  adder_4bit_rca #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       v;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] hold_s;
  logic       hold_co;
  logic       hold_ov;
  int         tests;
  int         fails;
  vec_t       vecs[6];

  task automatic cmp(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    cmp({tag, " out_valid"}, int'(bus.out_valid), int'(e.v));
    cmp({tag, " sum"}, int'(bus.sum), int'(e.s));
    cmp({tag, " cout"}, int'(bus.cout), int'(e.co));
`ifdef ADDER_OVERFLOW_EN
    cmp({tag, " overflow"}, int'(bus.overflow), int'(e.ov));
`endif
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, " out_valid"}, int'(bus.out_valid), 0);
    cmp({tag, " sum"}, int'(bus.sum), 0);
    cmp({tag, " cout"}, int'(bus.cout), 0);
`ifdef ADDER_OVERFLOW_EN
    cmp({tag, " overflow"}, int'(bus.overflow), 0);
`endif
  endtask

  function automatic exp_t model(input int a, input int b, input int cin, input logic v);
    exp_t e;
    int   tot, sa, sbv, ss;
    if (!v) begin
      e.v = 1'b0; e.s = hold_s; e.co = hold_co; e.ov = hold_ov;
      return e;
    end
    tot  = a + b + cin;
    sa   = (a > 7) ? a - 16 : a;
    sbv  = (b > 7) ? b - 16 : b;
    ss   = sa + sbv + cin;
    e.v  = 1'b1;
    e.s  = 4'(tot);
    e.co = (tot > 15);
    e.ov = (ss > 7) || (ss < -8);
    return e;
  endfunction

  // Drive one operand set between edges, push its expectation, check after the edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic v, input exp_t e, input string tag);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = v;
    sb_q.push_back(e);
    if (v) begin
      hold_s = e.s; hold_co = e.co; hold_ov = e.ov;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_zero({tag, " async"});
    @(posedge clk);
    #1;
    check_zero({tag, " held"});
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    hold_s = '0; hold_co = 1'b0; hold_ov = 1'b0;
  endtask

  initial begin
    exp_t e;
    tests = 0; fails = 0;
    hold_s = '0; hold_co = 1'b0; hold_ov = 1'b0;
    vecs[0] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, v: 1'b1, s: 4'd0,  co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 4'd5,  b: 4'd6,  cin: 1'b0, v: 1'b1, s: 4'd11, co: 1'b0, ov: 1'b1};
    vecs[2] = '{a: 4'd15, b: 4'd1,  cin: 1'b0, v: 1'b1, s: 4'd0,  co: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd15, cin: 1'b1, v: 1'b1, s: 4'd15, co: 1'b1, ov: 1'b0};
    vecs[4] = '{a: 4'd3,  b: 4'd4,  cin: 1'b0, v: 1'b1, s: 4'd7,  co: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd9,  cin: 1'b0, v: 1'b0, s: 4'd7,  co: 1'b0, ov: 1'b0};

    rst = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      e.v = vecs[i].v; e.s = vecs[i].s; e.co = vecs[i].co; e.ov = vecs[i].ov;
      step(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].v, e, $sformatf("vec%0d", i));
    end

    // Sum is 7 here; reset between edges must clear it without a clock.
    mid_cycle_reset("rst_mid");
    step(4'd0, 4'd0, 1'b0, 1'b1, model(0, 0, 0, 1'b1), "post_rst");

    for (int k = 0; k < 512; k++) begin
      int a, b, ci;
      a = k & 15; b = (k >> 4) & 15; ci = (k >> 8) & 1;
      step(4'(a), 4'(b), 1'(ci), 1'b1, model(a, b, ci, 1'b1), $sformatf("ex a=%0d b=%0d c=%0d", a, b, ci));
    end

    for (int k = 0; k < 4; k++) begin
      int a, b;
      a = $urandom_range(15); b = $urandom_range(15);
      step(4'(a), 4'(b), 1'b1, 1'b1, model(a, b, 1, 1'b1), $sformatf("stream%0d", k));
    end
    bus.a = 4'd12; bus.b = 4'd13; bus.cin = 1'b1; bus.in_valid = 1'b1;
    mid_cycle_reset("rst_stream");
    step(4'd12, 4'd13, 1'b1, 1'b1, model(12, 13, 1, 1'b1), "resume0");
    step(4'd7, 4'd8, 1'b0, 1'b1, model(7, 8, 0, 1'b1), "resume1");
    step(4'd1, 4'd1, 1'b0, 1'b0, model(1, 1, 0, 1'b0), "resume_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_4bit_rca.md
Name: adder_4bit_rca

Overview:
- Registered 4-bit ripple-carry adder.
- Combinational core is a structural chain of four 1-bit full adders, each computing sum = a^b^c and carry = ab | c(a^b).
- Carry ripples from bit 0 to bit 3; the result is captured into an output register.
- Used as a small arithmetic leaf in datapaths and as a lab reference for structural and dataflow modelling.

Parameters:
- WIDTH, 4, operand width. The block is specified and verified at 4 only; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- cin  input  1  carry into bit 0
- in_valid  input  1  operands valid this cycle
- sum  output  4  registered sum bits [3:0]
- cout  output  1  registered carry out of bit 3
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: while rst=1, sum=0, cout=0, out_valid=0, regardless of clk. Reset takes effect immediately on assertion, mid-operation included. First capture occurs on the first rising clk edge after deassertion.
- Combinational core: {c4, s[3:0]} = a + b + cin, built as four full-adder instances. c0 = cin; c(i+1) = carry of stage i; cout = c4.
- Arithmetic: exact 5-bit result {cout,sum} = a + b + cin, range 0..31. No saturation; wrap-around is carried only by cout.
- Latency: 1 cycle. At each rising clk edge with rst=0 and in_valid=1, sum<=s and cout<=c4, and out_valid<=1.
- Hold: at a rising edge with in_valid=0, out_valid<=0 while sum and cout hold their previous values. No back-pressure; a new operand set is accepted every cycle.
- Boundaries:
  - a=15, b=15, cin=1 -> {1,1111}.
  - a=15, b=1, cin=0 -> sum 0, cout 1.
  - a=0, b=0, cin=0 -> all zero.
- X handling: X on a, b or cin while in_valid=1 is not required to be cleaned; outputs may go X.

Optional Feature:
- Macro ADDER_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit, registered), equal to c3 XOR c4, i.e. two's-complement signed overflow of a+b+cin.
  - Reset value 0; updates and holds under the same rules as sum and cout.
- When undefined: the port and its logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously between edges with sum nonzero -> sum=0, cout=0, out_valid=0 immediately. Release rst, apply a=0, b=0, cin=0, in_valid=1 -> after one edge sum=0, cout=0, out_valid=1.
- Basic add: a=5, b=6, cin=0, in_valid=1 -> next edge sum=11, cout=0. With ADDER_OVERFLOW_EN, overflow=1 (signed 5+6 overflows 4 bits).
- Carry wrap:
  - a=15, b=1, cin=0 -> sum=0, cout=1.
  - a=15, b=15, cin=1 -> sum=15, cout=1.
  - With ADDER_OVERFLOW_EN, overflow=0 in both cases.
- Hold: apply a=3, b=4, then in_valid=0 with a=9, b=9 -> sum stays 7, cout 0, out_valid drops to 0 after the edge.
- Exhaustive: all 512 combinations of a, b, cin, one per cycle with in_valid=1 -> each cycle {cout,sum} equals a+b+cin from the previous cycle.
- Mid-stream reset: pulse rst during back-to-back valid inputs -> outputs zero during reset, correct results resume on the first edge after release.
